// File: rtl/dec_pipe_if.sv
// rtl/dec_pipe_if.sv - D-stage inputs and E-stage outputs of the decode pipe, grouped as one bus
interface dec_pipe_if #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
);
  localparam int RA_W = $clog2(NREG);

  logic              valid_d;
  logic [31:0]       inst_d;
  logic [DATA_W-1:0] pc_plus_4_d;
  logic              unsigned_d;
  logic              rf_we;
  logic [RA_W-1:0]   rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] alu_out_m;
  logic [DATA_W-1:0] result_w;
  logic [1:0]        fwd_a_d;
  logic [1:0]        fwd_b_d;
  logic [1:0]        branch_src;
  logic              stall_d;
  logic              flush_e;

  logic [4:0]        rs_d;
  logic [4:0]        rt_d;
  logic [DATA_W-1:0] next_br_d;
  logic              a_eq_b_d;
  logic              a_eq_z_d;
  logic              a_gt_z_d;
  logic              a_lt_z_d;
  logic              valid_e;
  logic [5:0]        opcode_e;
  logic [5:0]        funct_e;
  logic [4:0]        rs_e;
  logic [4:0]        rt_e;
  logic [4:0]        rd_e;
  logic [DATA_W-1:0] src_a_e;
  logic [DATA_W-1:0] src_b_e;
  logic [DATA_W-1:0] sign_imm_e;

  modport master (
    output valid_d, inst_d, pc_plus_4_d, unsigned_d, rf_we, rf_waddr, rf_wdata,
           alu_out_m, result_w, fwd_a_d, fwd_b_d, branch_src, stall_d, flush_e,
    input  rs_d, rt_d, next_br_d, a_eq_b_d, a_eq_z_d, a_gt_z_d, a_lt_z_d,
           valid_e, opcode_e, funct_e, rs_e, rt_e, rd_e, src_a_e, src_b_e, sign_imm_e
  );

  modport slave (
    input  valid_d, inst_d, pc_plus_4_d, unsigned_d, rf_we, rf_waddr, rf_wdata,
           alu_out_m, result_w, fwd_a_d, fwd_b_d, branch_src, stall_d, flush_e,
    output rs_d, rt_d, next_br_d, a_eq_b_d, a_eq_z_d, a_gt_z_d, a_lt_z_d,
           valid_e, opcode_e, funct_e, rs_e, rt_e, rd_e, src_a_e, src_b_e, sign_imm_e
  );
endinterface

// File: rtl/dec_pipe.sv
// rtl/dec_pipe.sv - MIPS decode stage: register file, forwarding, next-PC, flags, D->E register
// Optional: DEC_FWD_W_EN makes forward code 10 select result_w.
module dec_pipe #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic clk,
  input  logic rst_n,
  dec_pipe_if.slave bus
);
  localparam int RA_W = $clog2(NREG);

  logic [DATA_W-1:0] regs [NREG];
  logic [RA_W-1:0]   ra_a;
  logic [RA_W-1:0]   ra_b;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] sign_imm;
  logic [DATA_W-1:0] br_target;
  logic [DATA_W-1:0] jmp_target;

  assign bus.rs_d = bus.inst_d[25:21];
  assign bus.rt_d = bus.inst_d[20:16];
  assign ra_a     = bus.inst_d[21 +: RA_W];
  assign ra_b     = bus.inst_d[16 +: RA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (bus.rf_we && bus.rf_waddr != '0) begin
      regs[bus.rf_waddr] <= bus.rf_wdata;
    end
  end

  // Write-first: a same-cycle write to the read address is seen immediately.
  always_comb begin
    rf_a = regs[ra_a];
    rf_b = regs[ra_b];
    if (bus.rf_we && bus.rf_waddr == ra_a) rf_a = bus.rf_wdata;
    if (bus.rf_we && bus.rf_waddr == ra_b) rf_b = bus.rf_wdata;
    if (ra_a == '0) rf_a = '0;
    if (ra_b == '0) rf_b = '0;
  end

  always_comb begin
    src_a = rf_a;
    src_b = rf_b;
    case (bus.fwd_a_d)
      2'b01:   src_a = bus.alu_out_m;
`ifdef DEC_FWD_W_EN
      2'b10:   src_a = bus.result_w;
`endif
      default: src_a = rf_a;
    endcase
    case (bus.fwd_b_d)
      2'b01:   src_b = bus.alu_out_m;
`ifdef DEC_FWD_W_EN
      2'b10:   src_b = bus.result_w;
`endif
      default: src_b = rf_b;
    endcase
  end

`ifndef DEC_FWD_W_EN
  logic unused_result_w;
  assign unused_result_w = ^bus.result_w;
`endif

  assign imm16      = bus.inst_d[15:0];
  assign sign_imm   = bus.unsigned_d ? {{(DATA_W-16){1'b0}}, imm16}
                                     : {{(DATA_W-16){imm16[15]}}, imm16};
  assign br_target  = bus.pc_plus_4_d + {sign_imm[DATA_W-3:0], 2'b00};
  assign jmp_target = {bus.pc_plus_4_d[DATA_W-1:28], bus.inst_d[25:0], 2'b00};

  always_comb begin
    case (bus.branch_src)
      2'b00:   bus.next_br_d = br_target;
      2'b01:   bus.next_br_d = jmp_target;
      2'b10:   bus.next_br_d = src_a;
      default: bus.next_br_d = bus.pc_plus_4_d;
    endcase
  end

  assign bus.a_eq_b_d = (src_a == src_b);
  assign bus.a_eq_z_d = (src_a == '0);
  assign bus.a_gt_z_d = !src_a[DATA_W-1] && (src_a != '0);
  assign bus.a_lt_z_d = src_a[DATA_W-1];

  // Flush outranks stall so a squashed instruction never lingers in E.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.flush_e) begin
      bus.valid_e    <= 1'b0;
      bus.opcode_e   <= '0;
      bus.funct_e    <= '0;
      bus.rs_e       <= '0;
      bus.rt_e       <= '0;
      bus.rd_e       <= '0;
      bus.src_a_e    <= '0;
      bus.src_b_e    <= '0;
      bus.sign_imm_e <= '0;
    end else if (!bus.stall_d) begin
      bus.valid_e    <= bus.valid_d;
      bus.opcode_e   <= bus.inst_d[31:26];
      bus.funct_e    <= bus.inst_d[5:0];
      bus.rs_e       <= bus.inst_d[25:21];
      bus.rt_e       <= bus.inst_d[20:16];
      bus.rd_e       <= bus.inst_d[15:11];
      bus.src_a_e    <= src_a;
      bus.src_b_e    <= src_b;
      bus.sign_imm_e <= sign_imm;
    end
  end
endmodule
